trap_seq: RTL and testbench
===========================

TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter RESET_PRIV, default PRIV_M, SHALL set the privilege level loaded at reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 exc_valid  in  1  SHALL signal a synchronous exception from the committing instruction.
REQ-005 exc_cause  in  64  SHALL carry the exception mcause code; exc_tval  in  64  SHALL carry its trap value; exc_pc  in  64  SHALL carry the faulting pc.
REQ-006 mret_valid  in  1  SHALL signal a committing mret.
REQ-007 irq_pc  in  64  SHALL carry the pc of the next uncommitted instruction (interrupt return address).
REQ-008 mip_i, mie_i, mstatus_i, mtvec_i, mepc_i  in  64 each  SHALL carry current CSR values.
REQ-009 csr_we  out  1, csr_waddr  out  12, csr_wdata  out  64  SHALL form the single CSR write port.
REQ-010 redirect_valid  out  1 and redirect_pc  out  64  SHALL request a fetch redirect; flush  out  1  SHALL flush the pipeline.
REQ-011 busy  out  1  SHALL stall commit; priv  out  2  SHALL give the current privilege level.

Function
REQ-012 FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIR.
REQ-013 irq_pending = mip_i & mie_i & MIP_MASK, qualified by mstatus_i.mie or priv != PRIV_M; priority MEIP > MSIP > MTIP.
REQ-014 In IDLE, with exc_valid, the block SHALL accept the exception (captured as epc=exc_pc, cause=exc_cause, tval=exc_tval) and go to W_EPC.
REQ-015 In IDLE, when exc_valid=0 and an interrupt is pending, the block SHALL accept the interrupt (epc=irq_pc, cause=MCAUSE_INTERRUPT_MASK|code, tval=0) and go to W_EPC; priority: exception > interrupt > mret.
REQ-016 In IDLE, with mret_valid and no trap, the block SHALL go to R_STATUS.
REQ-017 busy SHALL assert combinationally in the accept cycle and remain high in every non-IDLE state.
REQ-018 W_EPC, W_CAUSE and W_TVAL SHALL each assert csr_we for exactly one cycle with CSR_MEPC/epc, CSR_MCAUSE/cause and CSR_MTVAL/tval, advancing in that order.
REQ-019 W_STATUS SHALL write CSR_MSTATUS with mpie=old mie, mie=0 and mpp=priv, and SHALL set priv=PRIV_M, then go to REDIR.
REQ-020 R_STATUS SHALL write CSR_MSTATUS with mie=old mpie, mpie=1 and mpp=PRIV_U, and SHALL set priv=old mpp, then go to REDIR.
REQ-021 REDIR SHALL pulse redirect_valid and flush for one cycle, then return to IDLE.
REQ-022 redirect_pc: trap = {mtvec_i[63:2],2'b00}, mret = mepc_i as sampled in REDIR.
REQ-023 Latency: trap accepted at cycle T gives redirect at T+5; mret accepted at T gives redirect at T+2.
REQ-024 Inputs arriving in non-IDLE states SHALL be ignored; the upstream holds them under busy.
REQ-025 Only MSTATUS_MASK bits of the written mstatus SHALL differ from mstatus_i.

Reset
REQ-026 Asserting reset_n low SHALL force IDLE, priv=RESET_PRIV and busy, csr_we, redirect_valid, flush, csr_waddr, csr_wdata, redirect_pc all 0.
REQ-027 Reset asserted mid-sequence SHALL abort it with no further CSR writes.

Configuration
REQ-028 With TRAP_VECTORED_EN defined and mtvec_i[1:0]=01, interrupt redirect_pc SHALL be base+4*code; exceptions always use base. Without the macro, mtvec mode is ignored and all traps use base.

Structure
REQ-029 The state enum and interrupt code constants SHALL go in csr_pkg, alongside the existing mstatus_t and MCAUSE_* definitions.
REQ-030 The interrupt priority encoder SHALL be the sub-module irq_prio (mip & mie in, valid and code out).

Verification
REQ-031 exc_valid, cause=2, exc_pc=0x8000_0010, tval=0xdead, mtvec=0x8000_1000 -> writes mepc=0x80000010, mcause=2, mtval=0xdead, then mstatus; redirect to 0x80001000 at T+5.
REQ-032 mie.MTIE=1, mip.MTIP=1, mstatus.mie=1, irq_pc=0x100 -> mcause=0x8000000000000007, mepc=0x100, mstatus.mie=0.
REQ-033 MEIP and MTIP both pending, simultaneous exc_valid -> exception taken, then mcause=0x800000000000000b on the next trap.
REQ-034 mret with mpp=00, mpie=1, mepc=0x2000 -> priv=PRIV_U, mie=1, redirect 0x2000 at T+2.
REQ-035 reset_n low during W_CAUSE -> no mtval/mstatus write, IDLE, priv=PRIV_M; with TRAP_VECTORED_EN and mtvec=0x1001, timer irq -> redirect 0x101C.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap sequencer: privilege levels, mstatus layout,
// CSR addresses, mcause encodings, interrupt codes and the sequencer state enum.
package csr_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_t;

    typedef struct packed {
        logic [50:0] hi;
        logic [1:0]  mpp;
        logic [2:0]  rsv_10_8;
        logic        mpie;
        logic [2:0]  rsv_6_4;
        logic        mie;
        logic [2:0]  rsv_2_0;
    } mstatus_t;

    typedef enum logic [2:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWTval,
        StWStatus,
        StRStatus,
        StRedir
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [63:0] MCAUSE_INTERRUPT_MASK = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MSTATUS_MASK          = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MIP_MASK              = 64'h0000_0000_0000_0888;

    localparam logic [5:0] IRQ_M_SOFT  = 6'd3;
    localparam logic [5:0] IRQ_M_TIMER = 6'd7;
    localparam logic [5:0] IRQ_M_EXT   = 6'd11;

    function automatic logic [63:0] trap_mstatus(input logic [63:0] cur, input priv_t priv);
        mstatus_t s;
        s      = mstatus_t'(cur);
        s.mpie = s.mie;
        s.mie  = 1'b0;
        s.mpp  = priv;
        return s;
    endfunction

    function automatic logic [63:0] mret_mstatus(input logic [63:0] cur);
        mstatus_t s;
        s      = mstatus_t'(cur);
        s.mie  = s.mpie;
        s.mpie = 1'b1;
        s.mpp  = PRIV_U;
        return s;
    endfunction

endpackage

// File: rtl/trap_seq_if.sv
// Bundle between the commit stage / CSR file (master) and the trap sequencer (slave).
interface trap_seq_if;
    logic        exc_valid;
    logic [63:0] exc_cause;
    logic [63:0] exc_tval;
    logic [63:0] exc_pc;
    logic        mret_valid;
    logic [63:0] irq_pc;
    logic [63:0] mip_i;
    logic [63:0] mie_i;
    logic [63:0] mstatus_i;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic        busy;
    logic [1:0]  priv;

    modport master (
        output exc_valid, exc_cause, exc_tval, exc_pc, mret_valid, irq_pc,
        output mip_i, mie_i, mstatus_i, mtvec_i, mepc_i,
        input  csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, flush, busy, priv
    );

    modport slave (
        input  exc_valid, exc_cause, exc_tval, exc_pc, mret_valid, irq_pc,
        input  mip_i, mie_i, mstatus_i, mtvec_i, mepc_i,
        output csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, flush, busy, priv
    );
endinterface

// File: rtl/irq_prio.sv
// Machine interrupt priority encoder: MEIP > MSIP > MTIP among enabled pending bits.
module irq_prio
    import csr_pkg::*;
(
    input  logic [63:0] mip_i,
    input  logic [63:0] mie_i,
    output logic        valid_o,
    output logic [5:0]  code_o
);
    logic [63:0] pend;
    logic        unused_pend;

    assign pend        = mip_i & mie_i & MIP_MASK;
    assign unused_pend = ^{pend[63:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        valid_o = 1'b1;
        code_o  = IRQ_M_EXT;
        if (pend[IRQ_M_EXT]) begin
            code_o = IRQ_M_EXT;
        end else if (pend[IRQ_M_SOFT]) begin
            code_o = IRQ_M_SOFT;
        end else if (pend[IRQ_M_TIMER]) begin
            code_o = IRQ_M_TIMER;
        end else begin
            valid_o = 1'b0;
        end
    end
endmodule

// File: rtl/trap_seq.sv
// Trap/mret sequencer: writes mepc/mcause/mtval/mstatus one per cycle, then redirects fetch.
// Optional TRAP_VECTORED_EN enables vectored interrupt targets when mtvec mode is 01.
module trap_seq
    import csr_pkg::*;
#(
    parameter priv_t RESET_PRIV = PRIV_M
) (
    input logic       clk,
    input logic       reset_n,
    trap_seq_if.slave bus
);
    trap_state_e state_q, state_d;
    priv_t       priv_q, priv_d;
    logic [63:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;
    logic        is_mret_q, is_mret_d;
    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_waddr_q, csr_waddr_d;
    logic [63:0] csr_wdata_q, csr_wdata_d;
    logic        redirect_q, redirect_d;

    logic        irq_valid, irq_take, accept;
    logic [5:0]  irq_code;
    logic [63:0] trap_base, trap_target;
    mstatus_t    mstatus;

    assign mstatus = mstatus_t'(bus.mstatus_i);

    irq_prio u_irq_prio (
        .mip_i   (bus.mip_i),
        .mie_i   (bus.mie_i),
        .valid_o (irq_valid),
        .code_o  (irq_code)
    );

    // Below M-mode, machine interrupts are taken regardless of mstatus.mie.
    assign irq_take = irq_valid & (mstatus.mie | (priv_q != PRIV_M));
    assign accept   = (state_q == StIdle) & (bus.exc_valid | irq_take | bus.mret_valid);

    assign trap_base = {bus.mtvec_i[63:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_target = (cause_q[63] && bus.mtvec_i[1:0] == 2'b01)
                         ? trap_base + {56'd0, cause_q[5:0], 2'b00} : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
    assign trap_target       = trap_base;
`endif

    always_comb begin
        state_d     = state_q;
        priv_d      = priv_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        is_mret_d   = is_mret_q;
        csr_we_d    = 1'b0;
        csr_waddr_d = 12'h000;
        csr_wdata_d = 64'd0;
        redirect_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.exc_valid || irq_take) begin
                    epc_d       = bus.exc_valid ? bus.exc_pc : bus.irq_pc;
                    cause_d     = bus.exc_valid ? bus.exc_cause
                                                : (MCAUSE_INTERRUPT_MASK | {58'd0, irq_code});
                    tval_d      = bus.exc_valid ? bus.exc_tval : 64'd0;
                    is_mret_d   = 1'b0;
                    state_d     = StWEpc;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_MEPC;
                    csr_wdata_d = epc_d;
                end else if (bus.mret_valid) begin
                    is_mret_d   = 1'b1;
                    priv_d      = priv_t'(mstatus.mpp);
                    state_d     = StRStatus;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_MSTATUS;
                    csr_wdata_d = mret_mstatus(bus.mstatus_i);
                end
            end
            StWEpc: begin
                state_d     = StWCause;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = cause_q;
            end
            StWCause: begin
                state_d     = StWTval;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MTVAL;
                csr_wdata_d = tval_q;
            end
            StWTval: begin
                state_d     = StWStatus;
                priv_d      = PRIV_M;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = trap_mstatus(bus.mstatus_i, priv_q);
            end
            StWStatus, StRStatus: begin
                state_d    = StRedir;
                redirect_d = 1'b1;
            end
            StRedir: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            priv_q      <= RESET_PRIV;
            epc_q       <= 64'd0;
            cause_q     <= 64'd0;
            tval_q      <= 64'd0;
            is_mret_q   <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= 12'h000;
            csr_wdata_q <= 64'd0;
            redirect_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            priv_q      <= priv_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            is_mret_q   <= is_mret_d;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            redirect_q  <= redirect_d;
        end
    end

    assign bus.csr_we         = csr_we_q;
    assign bus.csr_waddr      = csr_waddr_q;
    assign bus.csr_wdata      = csr_wdata_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.flush          = redirect_q;
    // Target is looked up live in REDIR so mepc_i/mtvec_i are sampled there.
    assign bus.redirect_pc    = redirect_q ? (is_mret_q ? bus.mepc_i : trap_target) : 64'd0;
    assign bus.busy           = reset_n & ((state_q != StIdle) | accept);
    assign bus.priv           = priv_q;
endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq with hand-computed CSR write and redirect values.
module tb_trap_seq;
    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;

    trap_seq_if bus ();

    trap_seq #(
        .RESET_PRIV (csr_pkg::PRIV_M)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] addr, input logic [63:0] data);
        check({tag, "_we"}, {63'd0, bus.csr_we}, 64'd1);
        check({tag, "_addr"}, {52'd0, bus.csr_waddr}, {52'd0, addr});
        check({tag, "_data"}, bus.csr_wdata, data);
    endtask

    // Called in the accept cycle; returns in the REDIR cycle (accept + 5).
    task automatic trap_body(input string tag, input logic [63:0] epc, input logic [63:0] cause,
                             input logic [63:0] tval, input logic [63:0] st,
                             input logic [63:0] pc);
        step(); chk_wr({tag, "_mepc"}, 12'h341, epc);
        step(); chk_wr({tag, "_mcause"}, 12'h342, cause);
        step(); chk_wr({tag, "_mtval"}, 12'h343, tval);
        step(); chk_wr({tag, "_mstatus"}, 12'h300, st);
        step();
        check({tag, "_redir_v"}, {63'd0, bus.redirect_valid}, 64'd1);
        check({tag, "_flush"}, {63'd0, bus.flush}, 64'd1);
        check({tag, "_redir_pc"}, bus.redirect_pc, pc);
        check({tag, "_redir_we"}, {63'd0, bus.csr_we}, 64'd0);
        check({tag, "_priv"}, {62'd0, bus.priv}, 64'd3);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        bus.exc_valid  = 1'b0;
        bus.exc_cause  = '0;
        bus.exc_tval   = '0;
        bus.exc_pc     = '0;
        bus.mret_valid = 1'b0;
        bus.irq_pc     = '0;
        bus.mip_i      = '0;
        bus.mie_i      = '0;
        bus.mstatus_i  = 64'h8;
        bus.mtvec_i    = 64'h8000_1000;
        bus.mepc_i     = '0;

        #12;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_we", {63'd0, bus.csr_we}, 64'd0);
        check("rst_redir", {63'd0, bus.redirect_valid}, 64'd0);
        check("rst_flush", {63'd0, bus.flush}, 64'd0);
        check("rst_waddr", {52'd0, bus.csr_waddr}, 64'd0);
        check("rst_wdata", bus.csr_wdata, 64'd0);
        check("rst_pc", bus.redirect_pc, 64'd0);
        check("rst_priv", {62'd0, bus.priv}, 64'd3);
        step();
        reset_n = 1'b1;
        step();

        // Exception with M-mode, mie=1: mstatus -> mpp=11, mpie=1, mie=0.
        bus.exc_valid = 1'b1;
        bus.exc_cause = 64'd2;
        bus.exc_pc    = 64'h8000_0010;
        bus.exc_tval  = 64'hdead;
        #1 check("exc_busy", {63'd0, bus.busy}, 64'd1);
        trap_body("exc", 64'h8000_0010, 64'd2, 64'hdead, 64'h1880, 64'h8000_1000);
        bus.exc_valid = 1'b0;
        step();
        check("exc_idle_busy", {63'd0, bus.busy}, 64'd0);
        check("exc_idle_redir", {63'd0, bus.redirect_valid}, 64'd0);

        // Machine timer interrupt.
        bus.mie_i  = 64'h80;
        bus.mip_i  = 64'h80;
        bus.irq_pc = 64'h100;
        #1 check("mti_busy", {63'd0, bus.busy}, 64'd1);
        trap_body("mti", 64'h100, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h8000_1000);
        bus.mip_i = '0;
        step();

        // Exception beats pending MEIP+MTIP; MEIP is taken right after.
        bus.mie_i     = 64'h880;
        bus.mip_i     = 64'h880;
        bus.irq_pc    = 64'h600;
        bus.exc_valid = 1'b1;
        bus.exc_cause = 64'd5;
        bus.exc_pc    = 64'h300;
        bus.exc_tval  = 64'h44;
        #1 check("pri_busy", {63'd0, bus.busy}, 64'd1);
        trap_body("pri_exc", 64'h300, 64'd5, 64'h44, 64'h1880, 64'h8000_1000);
        bus.exc_valid = 1'b0;
        step();
        check("pri_irq_busy", {63'd0, bus.busy}, 64'd1);
        check("pri_irq_we", {63'd0, bus.csr_we}, 64'd0);
        trap_body("pri_mei", 64'h600, 64'h8000_0000_0000_000b, 64'd0, 64'h1880, 64'h8000_1000);
        bus.mip_i = '0;
        step();

        // M-mode with mstatus.mie=0 masks the interrupt.
        bus.mstatus_i = 64'h0;
        bus.mie_i     = 64'h80;
        bus.mip_i     = 64'h80;
        #1 check("mask_busy", {63'd0, bus.busy}, 64'd0);
        step();
        check("mask_we", {63'd0, bus.csr_we}, 64'd0);
        check("mask_busy2", {63'd0, bus.busy}, 64'd0);
        bus.mip_i     = '0;
        bus.mstatus_i = 64'h8;
        step();

        // MSIP beats MTIP.
        bus.mie_i  = 64'h88;
        bus.mip_i  = 64'h88;
        bus.irq_pc = 64'h200;
        trap_body("msi", 64'h200, 64'h8000_0000_0000_0003, 64'd0, 64'h1880, 64'h8000_1000);
        bus.mip_i = '0;
        step();

        // Vectored mtvec: interrupts offset by 4*code when enabled, exceptions use base.
        bus.mtvec_i = 64'h1001;
        bus.mie_i   = 64'h80;
        bus.mip_i   = 64'h80;
        bus.irq_pc  = 64'h300;
`ifdef TRAP_VECTORED_EN
        trap_body("vec_mti", 64'h300, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h101c);
`else
        trap_body("vec_mti", 64'h300, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h1000);
`endif
        bus.mip_i = '0;
        step();
        bus.exc_valid = 1'b1;
        bus.exc_cause = 64'd4;
        bus.exc_pc    = 64'h400;
        bus.exc_tval  = 64'h8;
        trap_body("vec_exc", 64'h400, 64'd4, 64'h8, 64'h1880, 64'h1000);
        bus.exc_valid = 1'b0;
        step();

        // mret with mpp=00, mpie=1, mie=0 -> mie=1, mpie=1, mpp=00, priv U.
        bus.mstatus_i  = 64'h80;
        bus.mepc_i     = 64'h2000;
        bus.mret_valid = 1'b1;
        #1 check("mret_busy", {63'd0, bus.busy}, 64'd1);
        step();
        chk_wr("mret_mstatus", 12'h300, 64'h88);
        check("mret_priv", {62'd0, bus.priv}, 64'd0);
        bus.mret_valid = 1'b0;
        step();
        check("mret_redir_v", {63'd0, bus.redirect_valid}, 64'd1);
        check("mret_flush", {63'd0, bus.flush}, 64'd1);
        check("mret_redir_pc", bus.redirect_pc, 64'h2000);
        step();
        check("mret_idle_busy", {63'd0, bus.busy}, 64'd0);

        // Reset during W_CAUSE aborts the sequence.
        bus.exc_valid = 1'b1;
        bus.exc_cause = 64'd1;
        bus.exc_pc    = 64'h500;
        bus.exc_tval  = 64'h9;
        step();
        chk_wr("abort_mepc", 12'h341, 64'h500);
        step();
        chk_wr("abort_mcause", 12'h342, 64'd1);
        reset_n       = 1'b0;
        bus.exc_valid = 1'b0;
        #1;
        check("abort_we", {63'd0, bus.csr_we}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_priv", {62'd0, bus.priv}, 64'd3);
        step();
        check("abort_we2", {63'd0, bus.csr_we}, 64'd0);
        reset_n = 1'b1;
        step();
        check("abort_we3", {63'd0, bus.csr_we}, 64'd0);
        check("abort_busy3", {63'd0, bus.busy}, 64'd0);
        step();
        check("abort_we4", {63'd0, bus.csr_we}, 64'd0);
        check("abort_redir4", {63'd0, bus.redirect_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
